// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit -- multi-cycle main controller for the MIPS-lite datapath.
// Decodes op/funct from the instruction register and sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It generates the PC, IR,
// register-file and data-memory strobes, and drives the ALU (ALUctr, addi_sel).
//
// Parameters
//   OVF_SUPPRESS    : 1 = a signed overflow on addi cancels write-back
//   HALT_ON_ILLEGAL : 1 = an illegal instruction parks the FSM in HALT until reset
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   op, funct             : IR[31:26] and IR[5:0], held stable from DECODE onward
//   zero, overflow        : ALU flags
//   ALUctr, addi_sel      : ALU operation select and overflow-detect enable
//   PCWr, NPCsel, IRWr    : PC/IR update controls
//   RegWr, RegDst, ALUSrc, ExtOp, MemtoReg, MemWr : datapath controls
//   instr_done, illegal   : one-cycle status pulses
//   state                 : current FSM state (debug)
module mc_ctrl_unit #(
  parameter bit OVF_SUPPRESS    = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [2:0] ALUctr,
  output logic       addi_sel,
  output logic       PCWr,
  output logic [1:0] NPCsel,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic       MemtoReg,
  output logic       MemWr,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_ADDI, I_ADDIU,
    I_LW, I_SW, I_BEQ, I_J, I_ILL
  } instr_t;

  state_t     state_q, state_d;
  instr_t     cls;
  logic       ovf_r;
  logic [2:0] alu_sel;
  logic       src_sel, ext_sel, dst_sel;

  assign state = state_q;

  // Instruction classification
  always_comb begin
    cls = I_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: cls = I_ADDU;
          6'b100011: cls = I_SUBU;
          6'b101010: cls = I_SLT;
          default:   cls = I_ILL;
        endcase
      end
      6'b001101: cls = I_ORI;
      6'b001111: cls = I_LUI;
      6'b001000: cls = I_ADDI;
      6'b001001: cls = I_ADDIU;
      6'b100011: cls = I_LW;
      6'b101011: cls = I_SW;
      6'b000100: cls = I_BEQ;
      6'b000010: cls = I_J;
      default:   cls = I_ILL;
    endcase
  end

  // Datapath selects that stay fixed for the whole EXEC..WB span
  always_comb begin
    alu_sel = 3'b001;
    src_sel = 1'b0;
    ext_sel = 1'b0;
    dst_sel = 1'b0;
    case (cls)
      I_ADDU: dst_sel = 1'b1;
      I_SUBU: begin alu_sel = 3'b010; dst_sel = 1'b1; end
      I_SLT:  begin alu_sel = 3'b011; dst_sel = 1'b1; end
      I_ORI:  begin alu_sel = 3'b100; src_sel = 1'b1; end
      I_LUI:  begin alu_sel = 3'b000; src_sel = 1'b1; end
      I_ADDI, I_ADDIU, I_LW, I_SW: begin
        src_sel = 1'b1;
        ext_sel = 1'b1;
      end
      // The branch offset is a signed immediate; compare uses busB.
      I_BEQ:  begin alu_sel = 3'b010; ext_sel = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ovf_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH)
        ovf_r <= 1'b0;
      else if (state_q == S_EXEC)
        ovf_r <= overflow;
    end
  end

  // Next state and outputs; reset holds every output at its idle default.
  always_comb begin
    state_d    = state_q;
    ALUctr     = 3'b001;
    addi_sel   = 1'b0;
    PCWr       = 1'b0;
    NPCsel     = 2'b00;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    ExtOp      = 1'b0;
    MemtoReg   = 1'b0;
    MemWr      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (cls == I_ILL) begin
            illegal = 1'b1;
            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          ALUctr   = alu_sel;
          ALUSrc   = src_sel;
          ExtOp    = ext_sel;
          RegDst   = dst_sel;
          addi_sel = (cls == I_ADDI);
          case (cls)
            I_BEQ: begin
              PCWr       = zero;
              NPCsel     = 2'b01;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            I_J: begin
              PCWr       = 1'b1;
              NPCsel     = 2'b10;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            I_LW, I_SW: state_d = S_MEM;
            default:    state_d = S_WB;
          endcase
        end
        S_MEM: begin
          ALUctr = alu_sel;
          ALUSrc = src_sel;
          ExtOp  = ext_sel;
          RegDst = dst_sel;
          if (cls == I_SW) begin
            MemWr      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          ALUctr     = alu_sel;
          ALUSrc     = src_sel;
          ExtOp      = ext_sel;
          RegDst     = dst_sel;
          RegWr      = !((cls == I_ADDI) && ovf_r && OVF_SUPPRESS);
          MemtoReg   = (cls == I_LW);
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
